// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// MEM-stage data-memory access unit. Turns load/store instructions into
// SRAM-like bus requests (strobes, size, lane-replicated store data), flags
// misaligned accesses, stalls the pipeline until the bus completes, and hands
// the raw 32-bit read word to WB (extraction/sign extension happen in WB).
//
// Ports
//   clk, resetn                 core clock, async active-low reset
//   mem_valid, opM, addrM,      MEM-stage instruction, effective address and
//   wdataM                      store source value
//   flushM, pipe_adv            flush of the MEM instruction / MEM moves to WB
//   stallM                      hold MEM and earlier stages
//   adelM, adesM                load / store address error (combinational)
//   rdataM                      raw read word for WB
//   data_req/wr/size/addr/      bus request channel
//   wstrb/wdata
//   data_addr_ok, data_data_ok, bus handshake and read data
//   data_rdata
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter bit WORD_ADDR  = 1'b0,  // 1: force data_addr[1:0] to 2'b00
  parameter bit RDATA_HOLD = 1'b1   // 1: rdataM holds last word while not DONE
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [5:0]  opM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  input  logic        flushM,
  input  logic        pipe_adv,
  output logic        stallM,
  output logic        adelM,
  output logic        adesM,
  output logic [31:0] rdataM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_DISCARD, S_DONE
  } state_t;

  state_t      r_state;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [3:0]  r_strb;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_is_load;
  logic        w_is_store;
  logic [1:0]  w_size;
  logic        w_misalign;
  logic        w_legal;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic [31:0] w_addr;

  // Opcode decode: access class and size
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_size     = 2'd0;
    case (opM)
      OP_LB, OP_LBU: begin w_is_load  = 1'b1; w_size = 2'd0; end
      OP_LH, OP_LHU: begin w_is_load  = 1'b1; w_size = 2'd1; end
      OP_LW:         begin w_is_load  = 1'b1; w_size = 2'd2; end
      OP_SB:         begin w_is_store = 1'b1; w_size = 2'd0; end
      OP_SH:         begin w_is_store = 1'b1; w_size = 2'd1; end
      OP_SW:         begin w_is_store = 1'b1; w_size = 2'd2; end
      default: ;
    endcase
  end

  assign w_misalign = ((w_size == 2'd1) && addrM[0]) ||
                      ((w_size == 2'd2) && (addrM[1:0] != 2'b00));
  assign adelM = mem_valid & w_is_load  & w_misalign;
  assign adesM = mem_valid & w_is_store & w_misalign;

  // resetn is folded in so a held MEM instruction cannot raise a request
  // while the block is being reset.
  assign w_legal = resetn & mem_valid & (w_is_load | w_is_store) &
                   ~adelM & ~adesM & ~flushM;

  // Store lane encoding; loads carry no strobes and no data
  always_comb begin
    w_strb  = 4'b0000;
    w_wdata = 32'h0;
    if (w_is_store) begin
      case (w_size)
        2'd0: begin
          w_strb  = 4'b0001 << addrM[1:0];
          w_wdata = {4{wdataM[7:0]}};
        end
        2'd1: begin
          w_strb  = addrM[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{wdataM[15:0]}};
        end
        default: begin
          w_strb  = 4'b1111;
          w_wdata = wdataM;
        end
      endcase
    end
  end

  assign w_addr = WORD_ADDR ? {addrM[31:2], 2'b00} : addrM;

  // Transaction FSM. Bus fields are captured at issue so they stay stable in
  // REQ even if the MEM-stage inputs move.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'h0;
      r_strb  <= 4'b0000;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_legal) begin
            r_wr    <= w_is_store;
            r_size  <= w_size;
            r_addr  <= w_addr;
            r_strb  <= w_strb;
            r_wdata <= w_wdata;
            r_state <= data_addr_ok ? S_WAIT : S_REQ;
          end
        end
        S_REQ: begin
          // A flush racing the acceptance still leaves a transaction in
          // flight, so its response must be drained.
          if (data_addr_ok) r_state <= flushM ? S_DISCARD : S_WAIT;
          else if (flushM)  r_state <= S_IDLE;
        end
        S_WAIT: begin
          if (data_data_ok) begin
            if (flushM) begin
              r_state <= S_IDLE;
            end else begin
              r_rdata <= data_rdata;
              r_state <= S_DONE;
            end
          end else if (flushM) begin
            r_state <= S_DISCARD;
          end
        end
        S_DISCARD: if (data_data_ok) r_state <= S_IDLE;
        S_DONE:    if (pipe_adv || flushM) r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Bus channel: IDLE issues straight from the decode, REQ replays the
  // captured copy, every other state keeps the bus quiet.
  always_comb begin
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = 32'h0;
    data_wstrb = 4'b0000;
    data_wdata = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_legal) begin
          data_req   = 1'b1;
          data_wr    = w_is_store;
          data_size  = w_size;
          data_addr  = w_addr;
          data_wstrb = w_strb;
          data_wdata = w_wdata;
        end
      end
      S_REQ: begin
        data_req   = 1'b1;
        data_wr    = r_wr;
        data_size  = r_size;
        data_addr  = r_addr;
        data_wstrb = r_strb;
        data_wdata = r_wdata;
      end
      default: ;
    endcase
  end

  assign stallM = ((r_state == S_IDLE) && w_legal) || (r_state == S_REQ) ||
                  (r_state == S_WAIT) || (r_state == S_DISCARD);

  assign rdataM = (RDATA_HOLD || (r_state == S_DONE)) ? r_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
// Self-checking bench for dmem_access_ctrl. Expected bus requests and read
// words are queued when an access is driven and popped when the DUT shows
// the corresponding request acceptance or DONE cycle.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bus_t;

  logic        clk;
  logic        resetn;
  logic        mem_valid;
  logic [5:0]  opM;
  logic [31:0] addrM;
  logic [31:0] wdataM;
  logic        flushM;
  logic        pipe_adv;
  logic        stallM;
  logic        adelM;
  logic        adesM;
  logic [31:0] rdataM;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int          tests = 0;
  int          fails = 0;
  bus_t        exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] last_rdata = 32'h0;

  dmem_access_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .mem_valid    (mem_valid),
    .opM          (opM),
    .addrM        (addrM),
    .wdataM       (wdataM),
    .flushM       (flushM),
    .pipe_adv     (pipe_adv),
    .stallM       (stallM),
    .adelM        (adelM),
    .adesM        (adesM),
    .rdataM       (rdataM),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bus_t mk(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                              input logic [3:0] strb, input logic [31:0] wdata);
    bus_t b;
    b.wr = wr; b.size = size; b.addr = addr; b.strb = strb; b.wdata = wdata;
    return b;
  endfunction

  function automatic bus_t cur_bus();
    return mk(data_wr, data_size, data_addr, data_wstrb, data_wdata);
  endfunction

  task automatic idle_inputs();
    mem_valid = 1'b0; opM = 6'h0; addrM = 32'h0; wdataM = 32'h0;
    flushM = 1'b0; pipe_adv = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
  endtask

  // Full access: request held ok_delay cycles, data_ok in the first WAIT
  // cycle, one DONE cycle with pipe_adv. MEM inputs are perturbed while in
  // REQ to show the bus fields come from the captured copy.
  task automatic run_access(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                            input bus_t exp_b, input int ok_delay, input logic [31:0] rd,
                            output int stall_cyc, output int req_cyc);
    bus_t        eb;
    logic [31:0] er;
    stall_cyc = 0;
    req_cyc   = 0;
    exp_q.push_back(exp_b);
    if (!exp_b.wr) rd_q.push_back(rd);
    @(negedge clk);
    mem_valid = 1'b1; opM = op; addrM = addr; wdataM = wd;
    for (int c = 0; c <= ok_delay; c++) begin
      if (c > 0) begin
        @(negedge clk);
        addrM  = addr ^ 32'h0000_0100;
        wdataM = ~wd;
      end
      data_addr_ok = (c == ok_delay);
      #2;
      if (data_req) req_cyc++;
      if (stallM)   stall_cyc++;
      tests++;
      if (c == ok_delay) begin
        eb = exp_q.pop_front();
        if (data_req !== 1'b1 || cur_bus() !== eb) begin
          fails++;
          $display("FAIL issue_fields: req=%b bus=%h, required req=1 bus=%h", data_req, cur_bus(), eb);
        end
      end else if (data_req !== 1'b1 || cur_bus() !== exp_q[0]) begin
        fails++;
        $display("FAIL req_hold c=%0d: req=%b bus=%h, required req=1 bus=%h", c, data_req, cur_bus(), exp_q[0]);
      end
    end
    // WAIT: data_ok arrives together with a stray addr_ok, which must be ignored
    @(negedge clk);
    addrM = addr; wdataM = wd;
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = rd;
    #2;
    if (stallM) stall_cyc++;
    tests++;
    if (data_req !== 1'b0) begin
      fails++;
      $display("FAIL wait_req: req=%b, required 0", data_req);
    end
    // DONE
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0; pipe_adv = 1'b1;
    #2;
    if (stallM) stall_cyc++;
    tests++;
    if (stallM !== 1'b0 || data_req !== 1'b0) begin
      fails++;
      $display("FAIL done_quiet: stall=%b req=%b, required 0/0", stallM, data_req);
    end
    if (rd_q.size() != 0) begin
      er = rd_q.pop_front();
      tests++;
      if (rdataM !== er) begin
        fails++;
        $display("FAIL done_rdata: rdataM=%h, required %h", rdataM, er);
      end
    end
    last_rdata = rd;
    @(negedge clk);
    pipe_adv = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    #12;
    tests++;
    if ({stallM, adelM, adesM, rdataM, data_req, cur_bus()} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: stall=%b req=%b rdata=%h bus=%h, required all 0",
               stallM, data_req, rdataM, cur_bus());
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lw_min_latency();
    int sc, rc;
    run_access(OP_LW, 32'h8000_1004, 32'h0, mk(1'b0, 2'd2, 32'h8000_1004, 4'b0000, 32'h0),
               0, 32'hDEAD_BEEF, sc, rc);
    tests++;
    if (sc != 2 || rc != 1) begin
      fails++;
      $display("FAIL lw_latency: stall_cycles=%0d req_cycles=%0d, required 2/1", sc, rc);
    end
  endtask

  task automatic test_store_encode();
    int sc, rc;
    run_access(OP_SB, 32'h1000_0103, 32'h1234_5678, mk(1'b1, 2'd0, 32'h1000_0103, 4'b1000, 32'h7878_7878),
               0, 32'h0, sc, rc);
    run_access(OP_SH, 32'h1000_0202, 32'h0000_ABCD, mk(1'b1, 2'd1, 32'h1000_0202, 4'b1100, 32'hABCD_ABCD),
               0, 32'h0, sc, rc);
    run_access(OP_SW, 32'h4000_0008, 32'hCAFE_F00D, mk(1'b1, 2'd2, 32'h4000_0008, 4'b1111, 32'hCAFE_F00D),
               0, 32'h0, sc, rc);
  endtask

  task automatic test_misalign();
    logic [5:0]  ops [3]  = '{OP_SH, OP_LW, OP_LHU};
    logic [31:0] adrs [3] = '{32'h1000_0101, 32'h1000_0102, 32'h1000_0003};
    logic [3:0]  exps [3] = '{4'b1000, 4'b0100, 4'b0100};  // {ades, adel, req, stall}
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_valid = 1'b1; opM = ops[i]; addrM = adrs[i]; wdataM = 32'h0;
      #2;
      tests++;
      if ({adesM, adelM, data_req, stallM} !== exps[i]) begin
        fails++;
        $display("FAIL misalign_%0d: ades/adel/req/stall=%b, required %b", i, {adesM, adelM, data_req, stallM}, exps[i]);
      end
    end
    @(negedge clk);
    mem_valid = 1'b0;
    #2;
    tests++;
    if (data_req !== 1'b0 || stallM !== 1'b0) begin
      fails++;
      $display("FAIL misalign_no_txn: req=%b stall=%b, required 0/0", data_req, stallM);
    end
  endtask

  task automatic test_delayed_addr_ok();
    int sc, rc;
    run_access(OP_LH, 32'h2000_0042, 32'h0, mk(1'b0, 2'd1, 32'h2000_0042, 4'b0000, 32'h0),
               3, 32'h0000_F00D, sc, rc);
    tests++;
    if (rc != 4 || sc != 5) begin
      fails++;
      $display("FAIL lh_delayed: req_cycles=%0d stall_cycles=%0d, required 4/5", rc, sc);
    end
  endtask

  task automatic test_flush_req();
    @(negedge clk);
    mem_valid = 1'b1; opM = OP_LW; addrM = 32'h5000_0000;
    #2;
    @(negedge clk);
    flushM = 1'b1;
    #2;
    tests++;
    if (data_req !== 1'b1) begin
      fails++;
      $display("FAIL flush_req_hold: req=%b, required 1", data_req);
    end
    @(negedge clk);
    flushM = 1'b0; mem_valid = 1'b0;
    #2;
    tests++;
    if (data_req !== 1'b0 || stallM !== 1'b0) begin
      fails++;
      $display("FAIL flush_req_drop: req=%b stall=%b, required 0/0", data_req, stallM);
    end
  endtask

  task automatic test_flush_wait();
    int seen_req;
    @(negedge clk);
    mem_valid = 1'b1; opM = OP_LW; addrM = 32'h6000_0010; data_addr_ok = 1'b1;
    #2;
    tests++;
    if (data_req !== 1'b1) begin
      fails++;
      $display("FAIL flush_wait_issue: req=%b, required 1", data_req);
    end
    @(negedge clk);
    data_addr_ok = 1'b0; flushM = 1'b1;
    @(negedge clk);
    flushM = 1'b0; mem_valid = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hBADB_AD00;
    #2;
    tests++;
    if (stallM !== 1'b1 || data_req !== 1'b0) begin
      fails++;
      $display("FAIL discard_state: stall=%b req=%b, required 1/0", stallM, data_req);
    end
    @(negedge clk);
    data_data_ok = 1'b0; data_rdata = 32'h0;
    #2;
    tests++;
    if (stallM !== 1'b0 || rdataM !== last_rdata) begin
      fails++;
      $display("FAIL discard_drop: stall=%b rdataM=%h, required 0/%h", stallM, rdataM, last_rdata);
    end
    seen_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      if (data_req) seen_req++;
    end
    tests++;
    if (seen_req != 0) begin
      fails++;
      $display("FAIL discard_no_reissue: req cycles=%0d, required 0", seen_req);
    end
  endtask

  task automatic test_stray_data_ok();
    @(negedge clk);
    data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
    @(negedge clk);
    data_data_ok = 1'b0; data_rdata = 32'h0;
    #2;
    tests++;
    if (rdataM !== last_rdata || stallM !== 1'b0) begin
      fails++;
      $display("FAIL idle_data_ok: rdataM=%h stall=%b, required %h/0", rdataM, stallM, last_rdata);
    end
  endtask

  task automatic test_reset_mid_txn();
    int sc, rc;
    @(negedge clk);
    mem_valid = 1'b1; opM = OP_LBU; addrM = 32'h3000_0003; data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    tests++;
    if ({stallM, rdataM, data_req, cur_bus()} !== '0) begin
      fails++;
      $display("FAIL reset_in_wait: stall=%b req=%b rdata=%h bus=%h, required all 0",
               stallM, data_req, rdataM, cur_bus());
    end
    @(negedge clk);
    mem_valid = 1'b0; resetn = 1'b1;
    last_rdata = 32'h0;
    run_access(OP_LBU, 32'h3000_0002, 32'h0, mk(1'b0, 2'd0, 32'h3000_0002, 4'b0000, 32'h0),
               0, 32'h0000_00C3, sc, rc);
    tests++;
    if (sc != 2) begin
      fails++;
      $display("FAIL post_reset_lbu: stall_cycles=%0d, required 2", sc);
    end
  endtask

  task automatic test_back_to_back();
    int sc, rc;
    run_access(OP_SB, 32'h7000_0000, 32'h0000_00EE, mk(1'b1, 2'd0, 32'h7000_0000, 4'b0001, 32'hEEEE_EEEE),
               0, 32'h0, sc, rc);
    run_access(OP_LW, 32'h7000_0004, 32'h0, mk(1'b0, 2'd2, 32'h7000_0004, 4'b0000, 32'h0),
               1, 32'h1357_9BDF, sc, rc);
    tests++;
    if (exp_q.size() != 0 || rd_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: pending req=%0d rdata=%0d, required 0/0", exp_q.size(), rd_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_lw_min_latency();
    test_store_encode();
    test_misalign();
    test_delayed_addr_ok();
    test_flush_req();
    test_flush_wait();
    test_stray_data_ok();
    test_reset_mid_txn();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
